// File: rtl/scaler.sv
// Requantises accumulator results: ((result * SCALING_FACTOR) >> SHIFT_AMOUNT) + OUTPUT_OFFSET,
// registered with a rotating cell index. Define SCALER_SATURATE_EN to clamp instead of wrap on overflow.
module scaler #(
  parameter int DATA_WIDTH     = 8,
  parameter int RESULT_WIDTH   = 16,
  parameter int INDEX_WIDTH    = 10,
  parameter int SCALING_FACTOR = 10,
  parameter int SHIFT_AMOUNT   = 1,
  parameter int OUTPUT_OFFSET  = 10,
  parameter int CELL_AMOUNT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RESULT_WIDTH:0]  input_result,
  output logic [INDEX_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0]  output_value,
  output logic                   output_enable
);

  localparam int WIDE = RESULT_WIDTH + 32;
  localparam logic [INDEX_WIDTH-1:0] LAST_CELL = INDEX_WIDTH'(CELL_AMOUNT - 1);

  logic                   in_valid;
  logic [WIDE-1:0]        product;
  logic [WIDE-1:0]        shifted;
  logic [WIDE-1:0]        scaled;
  logic [DATA_WIDTH-1:0]  narrowed;
  logic [INDEX_WIDTH-1:0] cell_count;

  assign in_valid = input_result[RESULT_WIDTH];

  // Wide intermediate so the multiply, shift and offset can never overflow.
  always_comb begin
    product = WIDE'(input_result[RESULT_WIDTH-1:0]) * WIDE'(SCALING_FACTOR);
    shifted = product >> SHIFT_AMOUNT;
    scaled  = shifted + WIDE'(OUTPUT_OFFSET);
  end

`ifdef SCALER_SATURATE_EN
  always_comb begin
    narrowed = scaled[DATA_WIDTH-1:0];
    if (|scaled[WIDE-1:DATA_WIDTH])
      narrowed = '1;
  end
`else
  logic unused_high_bits;
  assign unused_high_bits = |scaled[WIDE-1:DATA_WIDTH];
  assign narrowed = scaled[DATA_WIDTH-1:0];
`endif

  // The cell counter only advances on valid items, so bubbles do not disturb the index sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_enable <= 1'b0;
      output_value  <= '0;
      output_index  <= '0;
      cell_count    <= '0;
    end else if (in_valid) begin
      output_enable <= 1'b1;
      output_value  <= narrowed;
      output_index  <= cell_count;
      cell_count    <= (cell_count == LAST_CELL) ? '0 : cell_count + INDEX_WIDTH'(1);
    end else begin
      output_enable <= 1'b0;
      output_value  <= '0;
      output_index  <= '0;
    end
  end

endmodule

// File: tb/tb_scaler.sv
// Scoreboard bench for scaler: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_scaler;

  logic        clk;
  logic        rst;
  logic [16:0] input_result;
  logic [9:0]  output_index;
  logic [7:0]  output_value;
  logic        output_enable;

  typedef struct packed {
    logic [7:0] value;
    logic [9:0] index;
    logic       enable;
  } exp_t;

  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

`ifdef SCALER_SATURATE_EN
  localparam logic [7:0] OVF_EXP = 8'd255;
`else
  localparam logic [7:0] OVF_EXP = 8'd254;
`endif

  scaler dut (
    .clk           (clk),
    .rst           (rst),
    .input_result  (input_result),
    .output_index  (output_index),
    .output_value  (output_value),
    .output_enable (output_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the expectation is for the outputs after the next rising edge.
  task automatic apply_stimulus(input logic r, input logic v, input logic [15:0] res,
                                input logic [7:0] ev, input logic [9:0] ei, input logic ee);
    exp_t e;
    @(negedge clk);
    rst          = r;
    input_result = {v, res};
    e.value  = ev;
    e.index  = ei;
    e.enable = ee;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    vectors_applied++;
    if (output_value !== e.value || output_index !== e.index || output_enable !== e.enable) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: got value=%0d index=%0d enable=%0b, expected value=%0d index=%0d enable=%0b",
               vectors_applied, output_value, output_index, output_enable,
               e.value, e.index, e.enable);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : stimulus
    rst          = 1'b1;
    input_result = '0;

    // reset then idle
    apply_stimulus(1, 0, 16'd0,   8'd0,  10'd0, 0);
    apply_stimulus(1, 0, 16'd0,   8'd0,  10'd0, 0);

    // invalid then valid
    apply_stimulus(0, 0, 16'd1,   8'd0,  10'd0, 0);
    apply_stimulus(0, 1, 16'd1,   8'd15, 10'd0, 1);

    // back-to-back with index wrap
    apply_stimulus(0, 1, 16'd5,   8'd35, 10'd1, 1);
    apply_stimulus(0, 1, 16'd0,   8'd10, 10'd0, 1);
    apply_stimulus(0, 1, 16'd3,   8'd25, 10'd1, 1);
    apply_stimulus(0, 0, 16'd60,  8'd0,  10'd0, 0);

    // counter holds across a bubble
    apply_stimulus(0, 1, 16'd2,   8'd20, 10'd0, 1);
    apply_stimulus(0, 0, 16'hBEEF, 8'd0, 10'd0, 0);
    apply_stimulus(0, 1, 16'd4,   8'd30, 10'd1, 1);

    // overflow: scaled = 510
    apply_stimulus(0, 1, 16'd100, OVF_EXP, 10'd0, 1);

    // mid-stream reset drops the coincident input
    apply_stimulus(0, 1, 16'd3,   8'd25, 10'd1, 1);
    apply_stimulus(0, 1, 16'd0,   8'd10, 10'd0, 1);
    apply_stimulus(0, 1, 16'd1,   8'd15, 10'd1, 1);
    apply_stimulus(1, 1, 16'd7,   8'd0,  10'd0, 0);
    apply_stimulus(0, 1, 16'd7,   8'd45, 10'd0, 1);
    apply_stimulus(0, 0, 16'd0,   8'd0,  10'd0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/scaler.md
Name: scaler

Overview:
- Requantisation stage between the accumulator (result) array and the downstream output buffer.
- Each valid accumulator result is multiplied by SCALING_FACTOR, shifted right by SHIFT_AMOUNT, and offset by OUTPUT_OFFSET.
- The result is emitted as a DATA_WIDTH-bit value, one clock later, tagged with a rotating cell index 0..CELL_AMOUNT-1.

Parameters:
- DATA_WIDTH, 8, width of output_value.
- RESULT_WIDTH, 16, width of the unsigned result field of input_result.
- INDEX_WIDTH, 10, width of output_index.
- SCALING_FACTOR, 10, unsigned integer multiplier.
- SHIFT_AMOUNT, 1, logical right shift applied after the multiply.
- OUTPUT_OFFSET, 10, unsigned constant added after the shift.
- CELL_AMOUNT, 2, number of cells the index rotates through; must be >=1 and <= 2^INDEX_WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- input_result  input  RESULT_WIDTH+1  bit [RESULT_WIDTH] is the valid flag; bits [RESULT_WIDTH-1:0] are the unsigned result.
- output_index  output  INDEX_WIDTH  cell index of the current output.
- output_value  output  DATA_WIDTH  scaled value.
- output_enable  output  1  high when output_value/output_index carry a valid item.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered. Latency is exactly 1 cycle: input sampled at edge N appears on the outputs after edge N.
- Reset (rst=1 at an edge): output_value=0, output_index=0, output_enable=0, internal cell counter=0. Reset has priority over a valid input in the same cycle; that input is dropped.
- Arithmetic, all unsigned, on an internal width of at least RESULT_WIDTH+32 bits so that no intermediate overflows: scaled = ((result * SCALING_FACTOR) >> SHIFT_AMOUNT) + OUTPUT_OFFSET.
- Narrowing scaled to DATA_WIDTH follows the Optional Feature below.
- Valid input (flag=1), no reset:
  - output_enable<=1, output_value<=narrowed scaled, output_index<=counter.
  - counter<=counter+1, wrapping from CELL_AMOUNT-1 to 0.
  - With CELL_AMOUNT=1 the index is always 0.
- Invalid input (flag=0), no reset:
  - output_enable<=0, output_value<=0, output_index<=0.
  - counter holds its value, so the index sequence continues across bubbles.
- Result field is ignored when flag=0.
- No backpressure: a valid input is accepted every cycle, including back-to-back.

Optional Feature:
- Macro SCALER_SATURATE_EN.
- Defined: if scaled > 2^DATA_WIDTH-1, output_value = 2^DATA_WIDTH-1 (255 at defaults).
- Undefined: output_value = scaled[DATA_WIDTH-1:0] (modulo wrap).
- Values within range are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, input_result=0 -> value=0, index=0, enable=0 every cycle.
- Invalid then valid: {0,1} -> next cycle value=0/index=0/enable=0; then {1,1} -> value=15, index=0, enable=1.
- Back-to-back valid with index wrap (defaults): {1,5},{1,0},{1,3} -> (35,1,1),(10,0,1),(25,1,1); then {0,60} -> (0,0,0).
- Counter holds across a bubble: {1,2},{0,x},{1,4} -> (20,0,1),(0,0,0),(30,1,1).
- Overflow at defaults: {1,100}, scaled=510 -> value=255 with SCALER_SATURATE_EN, 254 without.
- Mid-stream reset: valid stream producing index 1, then rst=1 coinciding with input {1,7} -> outputs 0/0/0, input dropped; next {1,7} after release -> value=45, index=0.
